// File: rtl/ahb_default_slave_cfg.sv
// AHB-Lite default slave: answers unmapped accesses with a configurable ERROR or OKAY
// response after optional wait states, and keeps a sideband log of faulting accesses.
module ahb_default_slave_cfg #(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned RESP_MODE     = 0,
  parameter int unsigned WAIT_STATES   = 0,
  parameter int unsigned CNT_W         = 16,
  parameter logic [31:0] RDATA_PATTERN = 32'h0000_0000
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [DATA_W-1:0] HRDATA,
  input  logic              err_clr,
  output logic              err_irq,
  output logic [ADDR_W-1:0] fault_addr,
  output logic              fault_write,
  output logic [2:0]        fault_size,
  output logic [CNT_W-1:0]  fault_count
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2, S_DATA} state_t;

  localparam logic [3:0]        WLOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam state_t            RESP_ST = (RESP_MODE != 0) ? S_DATA : S_ERR1;
  localparam logic [DATA_W-1:0] PAT     = DATA_W'(RDATA_PATTERN);

  state_t            state, state_n;
  logic [3:0]        wcnt, wcnt_n;
  logic              cap_write, cap_write_n;
  logic              ready_n, resp_n;
  logic [DATA_W-1:0] rdata_n;
  logic              accept;
  logic              unused_ok;

  assign accept    = HSEL & HREADY & HTRANS[1];
  assign unused_ok = ^{HWDATA, HTRANS[0]};

  always_comb begin
    state_n     = state;
    wcnt_n      = wcnt;
    cap_write_n = cap_write;
    case (state)
      S_WAIT: begin
        if (wcnt == '0) state_n = RESP_ST;
        else            wcnt_n  = wcnt - 4'd1;
      end
      S_ERR1: state_n = S_ERR2;
      default: begin
        state_n = S_IDLE;
        if (accept) begin
          cap_write_n = HWRITE;
          if (WAIT_STATES > 0) begin
            state_n = S_WAIT;
            wcnt_n  = WLOAD;
          end else begin
            state_n = RESP_ST;
          end
        end
      end
    endcase
    // Outputs are decoded from the next state so they can be registered alongside it.
    ready_n = !(state_n == S_WAIT || state_n == S_ERR1);
    resp_n  = (state_n == S_ERR1 || state_n == S_ERR2);
    rdata_n = (state_n == S_DATA && !cap_write_n) ? PAT : '0;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= S_IDLE;
      wcnt      <= '0;
      cap_write <= 1'b0;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= '0;
    end else begin
      state     <= state_n;
      wcnt      <= wcnt_n;
      cap_write <= cap_write_n;
      HREADYOUT <= ready_n;
      HRESP     <= resp_n;
      HRDATA    <= rdata_n;
    end
  end

  // A new accept outranks a coincident clear, so the count restarts at one.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_irq     <= 1'b0;
      fault_addr  <= '0;
      fault_write <= 1'b0;
      fault_size  <= '0;
      fault_count <= '0;
    end else if (accept) begin
      err_irq     <= 1'b1;
      fault_addr  <= HADDR;
      fault_write <= HWRITE;
      fault_size  <= HSIZE;
      if (err_clr)                fault_count <= CNT_W'(1);
      else if (fault_count != '1) fault_count <= fault_count + CNT_W'(1);
    end else if (err_clr) begin
      err_irq     <= 1'b0;
      fault_count <= '0;
    end
  end

endmodule

// File: tb/tb_ahb_default_slave_cfg.sv
// Bench for ahb_default_slave_cfg: four differently configured instances share random
// bus stimulus and are compared every cycle against a transfer-age reference model.
module tb_ahb_default_slave_cfg;

  localparam int unsigned NDUT = 4;
  localparam int unsigned RM [NDUT] = '{0, 0, 1, 1};
  localparam int unsigned WS [NDUT] = '{0, 3, 0, 2};
  localparam int unsigned CW [NDUT] = '{16, 2, 16, 4};
  localparam logic [31:0] PT [NDUT] = '{32'h0, 32'h0, 32'hDEAD_BEEF, 32'h1234_5678};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        err_clr;

  logic        hreadyout [NDUT];
  logic        hresp     [NDUT];
  logic [31:0] hrdata    [NDUT];
  logic        irq       [NDUT];
  logic [31:0] faddr     [NDUT];
  logic        fwr       [NDUT];
  logic [2:0]  fsz       [NDUT];
  logic [15:0] fcnt      [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned CWG = CW[g];
    logic [CWG-1:0] cnt_l;
    ahb_default_slave_cfg #(
      .ADDR_W(32), .DATA_W(32), .RESP_MODE(RM[g]), .WAIT_STATES(WS[g]),
      .CNT_W(CWG), .RDATA_PATTERN(PT[g])
    ) u_dut (
      .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hreadyout[g]),
      .HREADYOUT(hreadyout[g]), .HRESP(hresp[g]), .HRDATA(hrdata[g]),
      .err_clr(err_clr), .err_irq(irq[g]), .fault_addr(faddr[g]),
      .fault_write(fwr[g]), .fault_size(fsz[g]), .fault_count(cnt_l)
    );
    assign fcnt[g] = 16'(cnt_l);
  end

  // Reference model: each transfer is described by its age in cycles since the accept edge.
  bit          m_active [NDUT];
  int unsigned m_age    [NDUT];
  bit          m_rd     [NDUT];
  int unsigned m_cnt    [NDUT];
  bit          m_irq    [NDUT];
  logic [31:0] m_addr   [NDUT];
  bit          m_wr     [NDUT];
  logic [2:0]  m_sz     [NDUT];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned tlen(input int unsigned k);
    return WS[k] + ((RM[k] != 0) ? 1 : 2);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      m_active[k] = 0; m_age[k] = 0; m_rd[k] = 0;
      m_cnt[k] = 0; m_irq[k] = 0; m_addr[k] = '0; m_wr[k] = 0; m_sz[k] = '0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < NDUT; k++) begin
      int unsigned t   = tlen(k);
      int unsigned max = (1 << CW[k]) - 1;
      bit rdy = !m_active[k] || (m_age[k] == t);
      bit acc = hsel && rdy && htrans[1];
      if (acc) begin
        m_active[k] = 1; m_age[k] = 1; m_rd[k] = !hwrite;
        m_addr[k] = haddr; m_wr[k] = hwrite; m_sz[k] = hsize; m_irq[k] = 1;
        m_cnt[k] = err_clr ? 1 : ((m_cnt[k] < max) ? m_cnt[k] + 1 : max);
      end else begin
        if (m_active[k]) begin
          if (m_age[k] == t) m_active[k] = 0;
          else               m_age[k]++;
        end
        if (err_clr) begin
          m_cnt[k] = 0; m_irq[k] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NDUT; k++) begin
      int unsigned t = tlen(k);
      bit          e_rdy = 1, e_resp = 0;
      logic [31:0] e_data = '0;
      if (m_active[k]) begin
        e_rdy  = (m_age[k] == t);
        e_resp = (RM[k] == 0) && (m_age[k] > WS[k]);
        if (RM[k] != 0 && m_age[k] == t && m_rd[k]) e_data = PT[k];
      end
      check_val($sformatf("d%0d HREADYOUT", k), 64'(hreadyout[k]), 64'(e_rdy));
      check_val($sformatf("d%0d HRESP", k), 64'(hresp[k]), 64'(e_resp));
      check_val($sformatf("d%0d HRDATA", k), 64'(hrdata[k]), 64'(e_data));
      check_val($sformatf("d%0d err_irq", k), 64'(irq[k]), 64'(m_irq[k]));
      check_val($sformatf("d%0d fault_addr", k), 64'(faddr[k]), 64'(m_addr[k]));
      check_val($sformatf("d%0d fault_write", k), 64'(fwr[k]), 64'(m_wr[k]));
      check_val($sformatf("d%0d fault_size", k), 64'(fsz[k]), 64'(m_sz[k]));
      check_val($sformatf("d%0d fault_count", k), 64'(fcnt[k]), 64'(m_cnt[k]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(input bit sel, input logic [1:0] tr, input bit wr,
                       input logic [31:0] addr, input logic [2:0] sz, input bit clr);
    hsel = sel; htrans = tr; hwrite = wr; haddr = addr; hsize = sz; err_clr = clr;
    hwdata = $urandom();
  endtask

  initial begin
    rst_n = 1'b1;
    drive(0, 2'b00, 0, '0, '0, 0);
    #1 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Single read to an unmapped address, then idle.
    drive(1, 2'b10, 0, 32'h4000_0010, 3'd2, 0);
    cycle();
    drive(1, 2'b00, 0, 32'h4000_0010, 3'd2, 0);
    repeat (5) cycle();

    // Write that puts the wait-state instance mid-WAIT, then an asynchronous reset.
    drive(1, 2'b10, 1, 32'h5000_0004, 3'd2, 0);
    cycle();
    drive(1, 2'b01, 0, 32'h5000_0008, 3'd0, 0);
    cycle();
    pulse_reset();
    drive(1, 2'b10, 0, 32'h6000_0000, 3'd1, 0);
    cycle();
    drive(0, 2'b00, 0, '0, '0, 0);
    repeat (5) cycle();

    // Back-to-back NONSEQs, then clears alone and coincident with accepts.
    drive(1, 2'b10, 0, 32'h7000_0000, 3'd2, 0);
    repeat (8) cycle();
    drive(1, 2'b00, 0, 32'h7000_0000, 3'd2, 1);
    cycle();
    drive(1, 2'b11, 1, 32'h7000_0040, 3'd0, 1);
    repeat (6) cycle();

    repeat (1500) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 1'($urandom()),
            ($urandom_range(0, 3) == 0) ? 32'h4000_0010 : $urandom(),
            3'($urandom_range(0, 2)), $urandom_range(0, 9) == 0);
      cycle();
      if ($urandom_range(0, 99) == 0) pulse_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_default_slave_cfg.md
Name: ahb_default_slave_cfg

Overview:
Parametrised default slave for the AHB-Lite interconnect. The decoder selects it for every unmapped address. Unlike the fixed single-cycle default slave, it:
- issues the protocol-correct two-cycle ERROR response, or optionally an OKAY read-as-zero/write-ignored response;
- inserts configurable wait states;
- logs the first and subsequent faulting accesses for software diagnosis through sideband status/interrupt ports.

Parameters:
ADDR_W, 32, HADDR width
DATA_W, 32, HRDATA/HWDATA width
RESP_MODE, 0, 0 = ERROR response; 1 = OKAY, reads return RDATA_PATTERN, writes ignored
WAIT_STATES, 0, wait cycles (HREADYOUT=0, HRESP=OKAY) before the response; range 0..15
CNT_W, 16, width of the saturating fault counter
RDATA_PATTERN, 32'h0000_0000, read data returned in RESP_MODE=1 (truncated to DATA_W)

Ports:
HCLK  input  1  bus clock
HRESETn  input  1  asynchronous active-low reset
HSEL  input  1  slave select from decoder
HADDR  input  ADDR_W  address
HTRANS  input  2  transfer type
HWRITE  input  1  write=1
HSIZE  input  3  transfer size
HWDATA  input  DATA_W  write data, ignored
HREADY  input  1  bus-level ready (previous transfer complete)
HREADYOUT  output  1  slave ready
HRESP  output  1  0=OKAY, 1=ERROR
HRDATA  output  DATA_W  read data
err_clr  input  1  single-cycle pulse; clears fault log, counter, irq
err_irq  output  1  sticky: set on any logged access
fault_addr  output  ADDR_W  HADDR of most recent logged access
fault_write  output  1  HWRITE of most recent logged access
fault_size  output  3  HSIZE of most recent logged access
fault_count  output  CNT_W  number of logged accesses, saturating at all-ones

Behaviour:
- One clock, HCLK; reset HRESETn is asynchronous, active-low. All outputs are registered.
- Reset values:
  - HREADYOUT=1, HRESP=0, HRDATA=0;
  - err_irq=0, fault_addr=0, fault_write=0, fault_size=0, fault_count=0;
  - FSM=IDLE.
- Accept condition at a rising edge: HSEL & HREADY & HTRANS[1] (NONSEQ or SEQ).
  - IDLE/BUSY transfers, or HSEL=0, produce the zero-wait OKAY response: HREADYOUT=1, HRESP=0.
- FSM states:
  - IDLE: HREADYOUT=1, HRESP=0, HRDATA=0. On accept: to WAIT if WAIT_STATES>0, else to ERR1 (RESP_MODE=0) or DATA (RESP_MODE=1).
  - WAIT: HREADYOUT=0, HRESP=0; counts WAIT_STATES cycles, then goes to ERR1 or DATA.
  - ERR1: HREADYOUT=0, HRESP=1; always to ERR2 next cycle.
  - ERR2: HREADYOUT=1, HRESP=1. Next state is IDLE, or follows the accept rules if a new transfer is accepted this cycle (back-to-back allowed; a master cancelling with HTRANS=IDLE here returns to IDLE).
  - DATA: HREADYOUT=1, HRESP=0, HRDATA=RDATA_PATTERN if the captured access was a read, else 0. Next state per accept rules, as in ERR2.
- Latency from the accept edge to transfer completion (HREADYOUT=1 sampled):
  - RESP_MODE=0: WAIT_STATES+2 cycles.
  - RESP_MODE=1: WAIT_STATES+1 cycles.
- Fault log, updated in both modes on every accept edge:
  - fault_addr/write/size <= HADDR/HWRITE/HSIZE;
  - fault_count increments, saturating at 2^CNT_W-1;
  - err_irq <= 1.
- err_clr alone: zeroes fault_count and err_irq; fault_addr/write/size are held.
- err_clr in the same cycle as an accept: the accept wins, giving fault_count=1, err_irq=1, and the log updated.
- HRESETn asserted mid-transfer: immediate return to reset values, no completion of the pending response.
- No storage; HWDATA never affects any output.

Test Plan:
- RESP_MODE=0, WAIT_STATES=0: NONSEQ read to 0x4000_0010 -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); fault_addr=0x4000_0010, fault_write=0, fault_count=1, err_irq=1.
- RESP_MODE=0, WAIT_STATES=3: NONSEQ write, HSIZE=2 -> 3 cycles HREADYOUT=0/HRESP=0, then the two-cycle ERROR; fault_write=1, fault_size=2.
- RESP_MODE=1, RDATA_PATTERN=0xDEAD_BEEF: read -> one cycle HRDATA=0xDEAD_BEEF, HRESP=0, HREADYOUT=1; a following write -> HRDATA=0, HRESP=0; fault_count=2.
- Back-to-back: a NONSEQ accepted during ERR2 -> immediate ERR1 on the next cycle. IDLE and BUSY transfers with HSEL=1 -> OKAY, zero wait, fault_count unchanged.
- CNT_W=2: five accepts -> fault_count saturates at 3. err_clr alone -> count=0, irq=0, addr held. err_clr coincident with an accept -> count=1, irq=1.
- HRESETn asserted during WAIT -> outputs at reset values asynchronously; a post-reset read completes with a normal response.
